// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: CPU-store transmit buffer feeding the ft232if send interface.
// A circular byte FIFO absorbs bursts of stores; a three-state drain FSM
// (IDLE -> SEND -> HOLD) hands bytes to ft232if one per send_flag pulse and
// ignores send_available for HOLDOFF cycles after each pulse.
// Optional feature macro: UART_TX_FIFO_CRLF_EN -- expands each queued LF
// (8'h0A) into CR (8'h0D) followed by LF on the send side.
module uart_tx_fifo #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned HOLDOFF = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    input  logic                     clr_ovf,
    input  logic                     send_available,
    output logic                     send_flag,
    output logic [7:0]               send_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned CW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        HOLD = 2'd2
    } state_e;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          ovf_q, ovf_d;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          send_flag_q, send_flag_d;
    logic [7:0]    send_data_q, send_data_d;
    logic          push;
    logic          pop;
    logic [7:0]    head;
`ifdef UART_TX_FIFO_CRLF_EN
    logic          cr_done_q, cr_done_d;
`endif

    assign head = mem_q[rptr_q];
    // full is the registered flag, so a pop in the same cycle never rescues a write
    assign push = wr_en && !full_q;

    // Drain FSM: next state, pop decision and the registered send outputs
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        send_flag_d = 1'b0;
        send_data_d = send_data_q;
        pop         = 1'b0;
`ifdef UART_TX_FIFO_CRLF_EN
        cr_done_d   = cr_done_q;
`endif
        case (state_q)
            IDLE: begin
                if (!empty_q && send_available) begin
                    state_d     = SEND;
                    send_flag_d = 1'b1;
`ifdef UART_TX_FIFO_CRLF_EN
                    // An LF at the head is sent twice through IDLE: first as CR
                    // (head kept), then as itself (popped).
                    if (head == 8'h0A && !cr_done_q) begin
                        send_data_d = 8'h0D;
                        cr_done_d   = 1'b1;
                    end else begin
                        send_data_d = head;
                        pop         = 1'b1;
                        cr_done_d   = 1'b0;
                    end
`else
                    send_data_d = head;
                    pop         = 1'b1;
`endif
                end
            end
            SEND: begin
                cnt_d   = CW'(HOLDOFF - 1);
                state_d = HOLD;
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pointer, occupancy and overflow bookkeeping
    always_comb begin
        wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = pop  ? rptr_q + 1'b1 : rptr_q;
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        full_d  = (level_d == LW'(DEPTH));
        empty_d = (level_d == '0);
        // A dropped write outranks a simultaneous clear
        if (wr_en && full_q) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            level_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            ovf_q       <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            send_flag_q <= 1'b0;
            send_data_q <= 8'h00;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            level_q     <= level_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            ovf_q       <= ovf_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            send_flag_q <= send_flag_d;
            send_data_q <= send_data_d;
        end
    end

`ifdef UART_TX_FIFO_CRLF_EN
    // Remembers that the CR for the current head LF has already gone out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cr_done_q <= 1'b0;
        end else begin
            cr_done_q <= cr_done_d;
        end
    end
`endif

    // Storage array; contents need no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= wr_data;
        end
    end

    assign send_flag = send_flag_q;
    assign send_data = send_data_q;
    assign level     = level_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign overflow  = ovf_q;

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Transmit buffer between the CPU store path (UART_TX_ADDR store strobe and byte) and the ft232if send interface.
- Absorbs bursts of CPU byte stores so that software does not poll send_available per byte.
- Drains bytes to ft232if one at a time using a send_flag pulse and a hold-off/ready handshake.
- Exposes level and overflow status so the load path can map them as a readable status word.

Parameters:
- DEPTH, 16: FIFO entries; power of two, minimum 2.
- HOLDOFF, 2: cycles after a send_flag pulse during which send_available is ignored; minimum 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous assert, active-low
- wr_en  in  1  CPU store strobe to the TX address; one byte per cycle
- wr_data  in  8  byte to enqueue
- clr_ovf  in  1  clears the sticky overflow flag
- send_available  in  1  from ft232if; high means it can accept a byte
- send_flag  out  1  one-cycle pulse to ft232if; registered
- send_data  out  8  byte to ft232if; registered, valid while send_flag is high
- level  out  $clog2(DEPTH)+1  current entry count
- full  out  1  level == DEPTH
- empty  out  1  level == 0
- overflow  out  1  sticky flag: a write was dropped

Behaviour:
- Reset: pointers 0, level 0, empty=1, full=0, overflow=0, send_flag=0, send_data=8'h00, FSM=IDLE. Memory contents are don't-care.
- Storage:
  - Circular buffer with read and write pointers of $clog2(DEPTH) bits; pointers wrap naturally at DEPTH-1 -> 0.
  - level, full and empty are registered and derived from the occupancy counter.
- Write:
  - wr_en && !full: store wr_data at wptr, wptr+1, level+1.
  - wr_en && full: write is dropped, overflow <= 1, no pointer or level change. This holds even if a pop happens in the same cycle, because full is evaluated on the registered value.
- Pop: occurs only in the SEND transition (below). rptr+1, level-1.
- Simultaneous push and pop (non-full, non-empty): level is unchanged and both pointers advance.
- Overflow flag:
  - clr_ovf clears it.
  - If clr_ovf and a dropped write occur in the same cycle, set wins and overflow stays 1.
- Drain FSM:
  - IDLE: if !empty && send_available, go to SEND. The FSM registers send_data <= mem[rptr], send_flag <= 1 and pops in the same edge.
  - SEND: send_flag <= 0. Load the hold-off counter with HOLDOFF-1 and go to HOLD.
  - HOLD: decrement the counter. At 0 go to IDLE. send_available is ignored throughout HOLD.
- Handshake timing:
  - send_flag is high for exactly one cycle per byte.
  - Minimum spacing between successive send_flag pulses is HOLDOFF+2 cycles.
- Latency: wr_en into an empty FIFO at edge N; empty drops after edge N; send_flag is high after edge N+1, provided send_available=1.
- Back-pressure: if send_available is low in IDLE, the FSM waits indefinitely and bytes stay queued.
- Reset mid-operation: all state returns to reset values asynchronously. Queued bytes are lost, and a pending send_flag is cleared immediately.

Optional Feature:
- Macro: UART_TX_FIFO_CRLF_EN.
- Defined:
  - When the head byte is 8'h0A and the CR for it is not yet sent, IDLE emits send_data=8'h0D without popping, then goes to SEND, HOLD, IDLE.
  - The following pass emits 8'h0A and pops it.
  - A 1-bit cr_done register tracks this; it is cleared on pop and on reset.
  - Level counts only queued bytes, so the CR occupies no entry.
- Undefined: all bytes pass through unmodified. cr_done logic is absent.

Test Plan:
- Reset then idle -> empty=1, level=0, full=0, overflow=0, send_flag=0, send_data=8'h00.
- send_available=1; write 8'h41 at edge N -> send_flag=1 with send_data=8'h41 after edge N+1; pulse is 1 cycle; level returns to 0.
- send_available=0; write 8'h00..8'h0F (DEPTH=16) -> full=1, level=16. 17th write of 8'hFF -> overflow=1, level stays 16. Raise send_available -> 8'h00..8'h0F sent in order, pulses HOLDOFF+2=4 cycles apart. clr_ovf -> overflow=0.
- Wrap and simultaneous push/pop: stream 40 bytes (8'h00..8'h27) while draining, keeping level between 1 and 15 -> output order matches input exactly, no overflow.
- Reset asserted between send_flag and end of HOLD with 5 bytes queued -> outputs return to reset values asynchronously; no further send_flag after release.
- With UART_TX_FIFO_CRLF_EN: write 8'h48, 8'h0A -> send_data sequence 8'h48, 8'h0D, 8'h0A. Without it -> 8'h48, 8'h0A.
